// File: rtl/hazard_scoreboard.sv
// Register-dependency scoreboard and issue controller between decode and EX.
// Optional `STALL_COUNT_EN adds a saturating 32-bit stall_count output.
module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int ALU_LAT  = 0,
    parameter int CW       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_gp_we,
    input  logic [4:0] id_cad,
    input  logic       id_is_load,
    input  logic       id_flush,
    input  logic       pipe_hold,
    output logic       id_stall,
    output logic       id_issue,
    output logic       ex_bubble,
    output logic       busy
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    logic [CW-1:0] cnt_r [0:31];
    logic          ex_bubble_r;
    logic          rs_hz_s;
    logic          rt_hz_s;
    logic          hz_s;
    logic          live_s;
    logic          stall_s;
    logic          issue_s;
    logic          set_s;
    logic [CW-1:0] set_val_s;
    logic          busy_s;

    // Hazard detection and issue decision; r0 never counts as pending.
    always_comb begin
        rs_hz_s   = id_use_rs && (id_rs != 5'd0) && (cnt_r[id_rs] != {CW{1'b0}});
        rt_hz_s   = id_use_rt && (id_rt != 5'd0) && (cnt_r[id_rt] != {CW{1'b0}});
        hz_s      = rs_hz_s || rt_hz_s;
        live_s    = id_valid && !id_flush;
        stall_s   = live_s && hz_s;
        issue_s   = live_s && !hz_s && !pipe_hold;
        set_s     = issue_s && id_gp_we && (id_cad != 5'd0);
        if (id_is_load) begin
            set_val_s = CW'(LOAD_LAT);
        end else begin
            set_val_s = CW'(ALU_LAT);
        end
    end

    // Any tracked register still counting down.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (cnt_r[i] != {CW{1'b0}}) begin
                busy_s = 1'b1;
            end else begin
                busy_s = busy_s;
            end
        end
    end

    // Countdown array and EX bubble flag; a new producer overrides the decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
            ex_bubble_r <= 1'b1;
        end else if (!pipe_hold) begin
            cnt_r[0] <= {CW{1'b0}};
            for (int i = 1; i < 32; i++) begin
                if (set_s && (id_cad == 5'(i))) begin
                    cnt_r[i] <= set_val_s;
                end else if (cnt_r[i] != {CW{1'b0}}) begin
                    cnt_r[i] <= cnt_r[i] - CW'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
            ex_bubble_r <= !issue_s;
        end else begin
            ex_bubble_r <= ex_bubble_r;
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_count_r;

    // Saturating count of cycles where decode stalls and the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= 32'd0;
        end else if (stall_s && !pipe_hold && (stall_count_r != 32'hFFFF_FFFF)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`endif

    assign id_stall  = stall_s;
    assign id_issue  = issue_s;
    assign ex_bubble = ex_bubble_r;
    assign busy      = busy_s;

endmodule
